mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares one external memory port between the instruction-fetch stage and the data-memory stage of the five-stage pipeline. It serialises requests, sequences each transfer with a ready-based handshake toward memory and a one-cycle acknowledge pulse back to the requester. Data accesses have priority, with a bounded-starvation guarantee for fetch. It sits between the pipeline's fetch/memory stages and the unified memory interface. Its acknowledges drive the pipeline stall logic.

---
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one memory port between fetch and data requesters
// Revision 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic [31:0] IData,
  output logic        IAck,
  input  logic        DReq,
  input  logic        DWe,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWData,
  output logic [31:0] DRData,
  output logic        DAck,
  output logic [31:0] MAddr,
  output logic [31:0] MWData,
  output logic        MRead,
  output logic        MWrite,
  input  logic [31:0] MRData,
  input  logic        MReady
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] streak;
  logic       data_go;

  // Data wins unless fetch has already waited through LIMIT data grants.
  assign data_go = DReq && (!IReq || (streak < LIMIT));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      streak <= 4'd0;
      MRead  <= 1'b0;
      MWrite <= 1'b0;
      MAddr  <= 32'd0;
      MWData <= 32'd0;
      IAck   <= 1'b0;
      DAck   <= 1'b0;
      IData  <= 32'd0;
      DRData <= 32'd0;
    end else begin
      IAck <= 1'b0;
      DAck <= 1'b0;
      case (state)
        IDLE: begin
          if (data_go) begin
            state  <= DBUSY;
            MAddr  <= DAddr;
            MWData <= DWData;
            MWrite <= DWe;
            MRead  <= !DWe;
            if (!IReq)
              streak <= 4'd0;
            else if (streak < LIMIT)
              streak <= streak + 4'd1;
          end else if (IReq) begin
            state  <= IBUSY;
            MAddr  <= IAddr;
            MRead  <= 1'b1;
            MWrite <= 1'b0;
            streak <= 4'd0;
          end
        end
        IBUSY: begin
          if (MReady) begin
            state <= IDLE;
            MRead <= 1'b0;
            IAck  <= 1'b1;
            IData <= MRData;
          end
        end
        DBUSY: begin
          if (MReady) begin
            state  <= IDLE;
            MRead  <= 1'b0;
            MWrite <= 1'b0;
            DAck   <= 1'b1;
            // A write completion leaves the last read value in place.
            if (!MWrite)
              DRData <= MRData;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : directed self-checking bench for mem_port_arbiter
// Revision 1.0
// ============================================================================
module tb_mem_port_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        IReq;
  logic [31:0] IAddr;
  logic [31:0] IData;
  logic        IAck;
  logic        DReq;
  logic        DWe;
  logic [31:0] DAddr;
  logic [31:0] DWData;
  logic [31:0] DRData;
  logic        DAck;
  logic [31:0] MAddr;
  logic [31:0] MWData;
  logic        MRead;
  logic        MWrite;
  logic [31:0] MRData;
  logic        MReady;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .IReq(IReq), .IAddr(IAddr), .IData(IData), .IAck(IAck),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData),
    .DRData(DRData), .DAck(DAck),
    .MAddr(MAddr), .MWData(MWData), .MRead(MRead), .MWrite(MWrite),
    .MRData(MRData), .MReady(MReady)
  );

  always #5 Clk = ~Clk;

  // Mutual-exclusion properties observed on every falling edge out of reset.
  always @(negedge Clk) begin
    if (Reset === 1'b0) begin
      checks++;
      if ((IAck && DAck) !== 1'b0) begin
        errors++;
        $display("FAIL ack_exclusive: IAck=%b DAck=%b required not both high", IAck, DAck);
      end
      checks++;
      if ((MRead && MWrite) !== 1'b0) begin
        errors++;
        $display("FAIL strobe_exclusive: MRead=%b MWrite=%b required not both high", MRead, MWrite);
      end
    end
  end

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic go_idle();
    IReq = 1'b0;
    DReq = 1'b0;
    MReady = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1; IReq = 1'b0; IAddr = 32'h0; DReq = 1'b1; DWe = 1'b0;
    DAddr = 32'h8; DWData = 32'h0; MRData = 32'h0; MReady = 1'b0;
    tick();
    tick();
    checks++;
    if ({MRead, MWrite, IAck, DAck} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0000", {MRead, MWrite, IAck, DAck});
    end
    checks++;
    if ({MAddr, MWData, IData, DRData} !== 128'd0) begin
      errors++;
      $display("FAIL reset_data: got %h required 0", {MAddr, MWData, IData, DRData});
    end
    Reset = 1'b0;
    checks++;
    if (MRead !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_c1: MRead=%b required 0", MRead);
    end
    tick();
    checks++;
    if (MRead !== 1'b1 || MAddr !== 32'h8) begin
      errors++;
      $display("FAIL reset_release_c2: MRead=%b MAddr=%h required 1 / 00000008", MRead, MAddr);
    end
    MReady = 1'b1;
    tick();
    DReq = 1'b0;
    go_idle();
  endtask

  task automatic test_fetch_zero_wait();
    int acks;
    IReq = 1'b1; IAddr = 32'h10; MRData = 32'hDEADBEEF; MReady = 1'b1;
    tick();
    checks++;
    if (MRead !== 1'b1 || MAddr !== 32'h10 || IAck !== 1'b0) begin
      errors++;
      $display("FAIL fetch_c1: MRead=%b MAddr=%h IAck=%b required 1 / 00000010 / 0", MRead, MAddr, IAck);
    end
    tick();
    checks++;
    if (IAck !== 1'b1 || IData !== 32'hDEADBEEF || MRead !== 1'b0) begin
      errors++;
      $display("FAIL fetch_c2: IAck=%b IData=%h MRead=%b required 1 / deadbeef / 0", IAck, IData, MRead);
    end
    // Held request: acks expected in cycles 4, 6 and 8.
    acks = 0;
    for (int c = 3; c <= 8; c++) begin
      tick();
      if (IAck === 1'b1) acks++;
    end
    checks++;
    if (acks !== 3) begin
      errors++;
      $display("FAIL fetch_rate: got %0d acks in 6 cycles required 3", acks);
    end
    go_idle();
  endtask

  task automatic test_data_write_wait();
    DReq = 1'b1; DWe = 1'b1; DAddr = 32'h20; DWData = 32'h55;
    MReady = 1'b0; MRData = 32'hFFFF_0000;
    tick();
    checks++;
    if (MAddr !== 32'h20 || MWData !== 32'h55) begin
      errors++;
      $display("FAIL write_addr: MAddr=%h MWData=%h required 00000020 / 00000055", MAddr, MWData);
    end
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (MWrite !== 1'b1 || MRead !== 1'b0 || DAck !== 1'b0) begin
        errors++;
        $display("FAIL write_hold c%0d: MWrite=%b MRead=%b DAck=%b required 1 / 0 / 0", c, MWrite, MRead, DAck);
      end
      if (c == 4) MReady = 1'b1;
      tick();
    end
    checks++;
    if (DAck !== 1'b1 || MWrite !== 1'b0 || DRData !== 32'h0) begin
      errors++;
      $display("FAIL write_ack: DAck=%b MWrite=%b DRData=%h required 1 / 0 / 00000000", DAck, MWrite, DRData);
    end
    DReq = 1'b0;
    tick();
    checks++;
    if (DAck !== 1'b0) begin
      errors++;
      $display("FAIL write_ack_pulse: DAck=%b required 0", DAck);
    end
    go_idle();
  endtask

  task automatic test_simultaneous();
    logic [31:0] exp_addr;
    IReq = 1'b1; IAddr = 32'h100; DReq = 1'b1; DWe = 1'b0; DAddr = 32'h200;
    MReady = 1'b1; MRData = 32'h0;
    for (int k = 0; k < 10; k++) begin
      tick();
      exp_addr = ((k % 5) == 4) ? 32'h100 : 32'h200;
      checks++;
      if (MRead !== 1'b1 || MAddr !== exp_addr) begin
        errors++;
        $display("FAIL grant_order[%0d]: MRead=%b MAddr=%h required 1 / %h", k, MRead, MAddr, exp_addr);
      end
      tick();
      if (k == 9) begin
        IReq = 1'b0;
        DReq = 1'b0;
      end
    end
    go_idle();
  endtask

  task automatic test_mid_reset();
    DReq = 1'b1; DWe = 1'b0; DAddr = 32'h30; MReady = 1'b0;
    tick();
    checks++;
    if (MRead !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy: MRead=%b required 1", MRead);
    end
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++;
    if (MRead !== 1'b0 || MWrite !== 1'b0 || DAck !== 1'b0) begin
      errors++;
      $display("FAIL midrst_abort: MRead=%b MWrite=%b DAck=%b required 0 / 0 / 0", MRead, MWrite, DAck);
    end
    tick();
    checks++;
    if (MRead !== 1'b1 || MAddr !== 32'h30 || DAck !== 1'b0) begin
      errors++;
      $display("FAIL midrst_reissue: MRead=%b MAddr=%h DAck=%b required 1 / 00000030 / 0", MRead, MAddr, DAck);
    end
    MReady = 1'b1; MRData = 32'h77;
    tick();
    checks++;
    if (DAck !== 1'b1 || DRData !== 32'h77) begin
      errors++;
      $display("FAIL midrst_done: DAck=%b DRData=%h required 1 / 00000077", DAck, DRData);
    end
    go_idle();
  endtask

  task automatic test_read_isolation();
    DReq = 1'b1; DWe = 1'b0; DAddr = 32'h40; MReady = 1'b1; MRData = 32'h1234;
    tick();
    tick();
    checks++;
    if (DAck !== 1'b1 || DRData !== 32'h1234) begin
      errors++;
      $display("FAIL iso_dread: DAck=%b DRData=%h required 1 / 00001234", DAck, DRData);
    end
    DReq = 1'b0; IReq = 1'b1; IAddr = 32'h44; MRData = 32'hABCD;
    tick();
    checks++;
    if (MRead !== 1'b1 || MAddr !== 32'h44) begin
      errors++;
      $display("FAIL iso_fetch_c1: MRead=%b MAddr=%h required 1 / 00000044", MRead, MAddr);
    end
    tick();
    checks++;
    if (IAck !== 1'b1 || IData !== 32'hABCD || DRData !== 32'h1234) begin
      errors++;
      $display("FAIL iso_fetch_c2: IAck=%b IData=%h DRData=%h required 1 / 0000abcd / 00001234", IAck, IData, DRData);
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_fetch_zero_wait();
    test_data_write_wait();
    test_simultaneous();
    test_mid_reset();
    test_read_isolation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
